// File: rtl/zx8x_vram_snoop_if.sv
// Bus bundle for the ZX80/81 VRAM snoop: raw Z80 write strobes in, clean
// video-buffer write pulses out.
interface zx8x_vram_snoop_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_mreq_n;
  logic        cpu_wr_n;
  logic [7:0]  buf_write;
  logic [12:0] buf_write_addr;
  logic        buf_we;

  modport master (
    input  cpu_addr, cpu_data, cpu_mreq_n, cpu_wr_n,
    output buf_write, buf_write_addr, buf_we
  );

  modport slave (
    output cpu_addr, cpu_data, cpu_mreq_n, cpu_wr_n,
    input  buf_write, buf_write_addr, buf_we
  );
endinterface

// File: rtl/zx8x_vram_snoop.sv
// Snoops asynchronous Z80 writes into the 0x2000-0x3FFF window, queues them and
// replays them as clean VRAM writes. Define ZX8X_SNOOP_MIRROR_EN to also accept 0xA000-0xBFFF.
module zx8x_vram_snoop #(
  parameter int SETTLE    = 3,
  parameter int WE_CYCLES = 2,
  parameter int FIFO_AW   = 3
) (
  input  logic              clk50m,
  input  logic              rst_n,
  zx8x_vram_snoop_if.master bus,
  output logic              overflow,
  output logic [FIFO_AW:0]  fifo_level
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE);
  localparam logic [3:0]       WE_LAST     = 4'(WE_CYCLES - 1);
  localparam logic [FIFO_AW:0] LEVEL_FULL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {CAP_WAIT, CAP_SETTLE, CAP_ARMED} cap_state_t;
  typedef enum logic [1:0] {DR_IDLE, DR_SETUP, DR_STROBE, DR_HOLD} drain_state_t;

  logic [2:0] sync_reg;
  logic       wr_act;
  logic       wr_sync;
  logic       wr_rise;
  logic       in_window;

  cap_state_t       cap_state_reg;
  logic [CNT_W-1:0] settle_cnt_reg;
  logic [20:0]      sample_reg;
  logic             sample_ok_reg;

  logic [20:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [FIFO_AW:0]   level_reg;
  logic               overflow_reg;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push_do;
  logic               pop_do;

  drain_state_t drain_state_reg;
  logic [3:0]   we_cnt_reg;
  logic         buf_we_reg;
  logic [12:0]  buf_addr_reg;
  logic [7:0]   buf_data_reg;

  assign wr_act  = ~bus.cpu_mreq_n & ~bus.cpu_wr_n;
  assign wr_sync = sync_reg[1];
  assign wr_rise = sync_reg[1] & ~sync_reg[2];

`ifdef ZX8X_SNOOP_MIRROR_EN
  assign in_window = (bus.cpu_addr[15:13] == 3'b001) || (bus.cpu_addr[15:13] == 3'b101);
`else
  assign in_window = (bus.cpu_addr[15:13] == 3'b001);
`endif

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], wr_act};
    end
  end

  // Bus lines are sampled raw: the settle delay guarantees they are stable by then.
  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      cap_state_reg  <= CAP_WAIT;
      settle_cnt_reg <= '0;
      sample_reg     <= '0;
      sample_ok_reg  <= 1'b0;
    end else begin
      case (cap_state_reg)
        CAP_WAIT: begin
          if (wr_rise) begin
            settle_cnt_reg <= '0;
            cap_state_reg  <= CAP_SETTLE;
          end
        end
        CAP_SETTLE: begin
          if (!wr_sync) begin
            cap_state_reg <= CAP_WAIT;
          end else if (settle_cnt_reg == SETTLE_LAST) begin
            sample_reg    <= {bus.cpu_addr[12:0], bus.cpu_data};
            sample_ok_reg <= in_window;
            cap_state_reg <= CAP_ARMED;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        CAP_ARMED: begin
          sample_ok_reg <= 1'b0;
          if (!wr_sync) begin
            cap_state_reg <= CAP_WAIT;
          end
        end
        default: cap_state_reg <= CAP_WAIT;
      endcase
    end
  end

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LEVEL_FULL);
  assign pop_do     = (drain_state_reg == DR_IDLE) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_do    = sample_ok_reg && (!fifo_full || pop_do);

  always_ff @(posedge clk50m) begin
    if (push_do) begin
      mem[wr_ptr_reg] <= sample_reg;
    end
  end

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_do) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_do) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_do && !pop_do) begin
        level_reg <= level_reg + 1'b1;
      end else if (pop_do && !push_do) begin
        level_reg <= level_reg - 1'b1;
      end
      if (sample_ok_reg && !push_do) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      drain_state_reg <= DR_IDLE;
      we_cnt_reg      <= '0;
      buf_we_reg      <= 1'b0;
      buf_addr_reg    <= '0;
      buf_data_reg    <= '0;
    end else begin
      case (drain_state_reg)
        DR_IDLE: begin
          if (pop_do) begin
            {buf_addr_reg, buf_data_reg} <= mem[rd_ptr_reg];
            drain_state_reg              <= DR_SETUP;
          end
        end
        DR_SETUP: begin
          buf_we_reg      <= 1'b1;
          we_cnt_reg      <= '0;
          drain_state_reg <= DR_STROBE;
        end
        DR_STROBE: begin
          if (we_cnt_reg == WE_LAST) begin
            buf_we_reg      <= 1'b0;
            drain_state_reg <= DR_HOLD;
          end else begin
            we_cnt_reg <= we_cnt_reg + 1'b1;
          end
        end
        DR_HOLD: drain_state_reg <= DR_IDLE;
        default: drain_state_reg <= DR_IDLE;
      endcase
    end
  end

  assign bus.buf_we         = buf_we_reg;
  assign bus.buf_write_addr = buf_addr_reg;
  assign bus.buf_write      = buf_data_reg;
  assign overflow           = overflow_reg;
  assign fifo_level         = level_reg;
endmodule
